pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter sequencer for the CSE141L core. Owns ProgCtr and sequences instruction fetch.
- Drives the branch-target LUT with a 4-bit branch index and loads the returned 8-bit target when a branch is taken.
- Handles program start, stall, halt/done signalling and a run-cycle counter.
- Sits between the decoder/ALU flags and instruction ROM; the LUT is instantiated beside it at the top level.

Parameters:
PC_W, 8, program counter / ROM address width
LUT_AW, 4, branch-LUT index width
CNT_W, 16, run-cycle counter width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  start pulse; loads StartAddr and begins execution
StartAddr  in  PC_W  entry address of program to run
Stall  in  1  freeze PC this cycle (fetch/memory not ready)
Halt  in  1  decoded halt instruction at current ProgCtr
BranchReq  in  1  decoded branch instruction at current ProgCtr
BranchCond  in  1  branch condition flag from ALU (1 = take)
BranchIdx  in  LUT_AW  LUT index field of branch instruction
LutAddr  out  LUT_AW  index to branch LUT
LutTarget  in  PC_W  target address returned by LUT
ProgCtr  out  PC_W  current instruction address
Running  out  1  1 while in RUN
Done  out  1  1 while in HALTED
BranchTaken  out  1  one-cycle registered pulse after a taken branch
CycleCnt  out  CNT_W  RUN cycles since last Start, saturating

Behaviour:
- Interface: one clock, Clk; reset is Reset, synchronous and active-high. All state updates on the rising Clk edge.
- Reset values: ProgCtr=0, state=IDLE, Running=0, Done=0, BranchTaken=0, CycleCnt=0. Reset asserted mid-RUN or mid-branch aborts everything at that edge; no pending actions survive.
- LutAddr = BranchIdx, combinational and always driven. The LUT is combinational; LutTarget is sampled in the same cycle.
- States: IDLE, RUN, HALTED. Running = (state==RUN), Done = (state==HALTED), both decoded from registered state.
- IDLE:
  - Start=1 -> ProgCtr<=StartAddr, CycleCnt<=0, state<=RUN.
  - Otherwise hold. Halt, BranchReq and Stall are ignored in IDLE.
- RUN, priority order each cycle:
  1. Halt=1 -> state<=HALTED, ProgCtr holds (points at the halt instruction).
  2. Stall=1 -> ProgCtr holds. A branch or halt presented that cycle is not consumed; the decoder re-presents it.
  3. BranchReq & BranchCond -> ProgCtr<=LutTarget, BranchTaken<=1 next cycle.
  4. Otherwise (including BranchReq & !BranchCond) -> ProgCtr<=ProgCtr+1.
- Increment wraps: 255 -> 0 for PC_W=8. No flag is raised.
- BranchTaken is 1 only for the cycle after a taken-branch edge, else 0.
- Start during RUN is ignored.
- CycleCnt:
  - Increments every cycle in RUN, including stalled cycles and the halt cycle.
  - Saturates at 2^CNT_W-1.
  - Holds in HALTED and IDLE; cleared on an accepted Start.
- HALTED: ProgCtr and CycleCnt hold. Start=1 behaves exactly as in IDLE: load StartAddr, clear CycleCnt, go to RUN; Done drops the next cycle.
- Simultaneous Halt and BranchReq: Halt wins. Simultaneous Halt and Stall: Halt wins.
- Latency: one cycle from Start to Running=1 and ProgCtr=StartAddr. One cycle from the taken-branch edge to ProgCtr=target.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W and LUT_AW constants (shared with the LUT, instruction ROM and decoder).
  - The seq_state_t enum {IDLE, RUN, HALTED}.
- Single flat module. No sub-module is warranted; the saturating CycleCnt is a few lines inline.
- The LUT stays a separate, existing module wired at the top level.

Test Plan:
- Reset, then Start with StartAddr=4 -> next cycle ProgCtr=4, Running=1; after 3 idle cycles ProgCtr=7, CycleCnt=3.
- In RUN: BranchReq=1, BranchCond=1, BranchIdx=2, bench LUT returns 228 -> LutAddr=2, next cycle ProgCtr=228, BranchTaken pulses for exactly one cycle. Same with BranchCond=0 -> ProgCtr+1, BranchTaken stays 0.
- ProgCtr=255 with no branch -> next ProgCtr=0. Stall=1 for 2 cycles with BranchReq=1 -> ProgCtr holds; CycleCnt still advances by 2.
- Halt and BranchReq together at ProgCtr=50 -> HALTED, Done=1, ProgCtr=50. A following Start with StartAddr=0 -> RUN, ProgCtr=0, CycleCnt=0, Done=0.
- Reset asserted one cycle after a taken-branch edge -> next edge ProgCtr=0, IDLE, BranchTaken=0. Force CycleCnt near max (CNT_W=4 build) -> saturates at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CSE141L core: fetch/branch widths and the
// program-counter sequencer state encoding.
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns ProgCtr, walks the instruction ROM, redirects
// through the branch-target LUT and tracks how long the current program has run.
module pc_sequencer #(
  parameter int PC_W   = cpu_pkg::PC_W,
  parameter int LUT_AW = cpu_pkg::LUT_AW,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              BranchReq,
  input  logic              BranchCond,
  input  logic [LUT_AW-1:0] BranchIdx,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutTarget,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done,
  output logic              BranchTaken,
  output logic [CNT_W-1:0]  CycleCnt
);

  import cpu_pkg::*;

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_q, taken_d;

  // The LUT is combinational, so its index follows the decoder field directly.
  assign LutAddr = BranchIdx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  // In RUN, halt outranks stall, which outranks branch; a stalled branch is re-presented later.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    taken_d = 1'b0;
    unique case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = StartAddr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (Halt) begin
          state_d = HALTED;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (BranchReq && BranchCond) begin
          pc_d    = LutTarget;
          taken_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ProgCtr     = pc_q;
  assign Running     = (state_q == RUN);
  assign Done        = (state_q == HALTED);
  assign BranchTaken = taken_q;
  assign CycleCnt    = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main RUN behaviour, plus
// hand sequences for reset-after-branch, IDLE input masking and counter saturation.
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] startAddr;
  logic       stall, halt, branchReq, branchCond;
  logic [3:0] branchIdx, lutAddr;
  logic [7:0] lutTarget, progCtr;
  logic       running, done, branchTaken;
  logic [15:0] cycleCnt;

  logic       reset4, start4;
  logic [3:0] lutAddr4;
  logic [7:0] progCtr4;
  logic       running4, done4, branchTaken4;
  logic [3:0] cycleCnt4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .Clk(clock), .Reset(reset), .Start(start), .StartAddr(startAddr),
    .Stall(stall), .Halt(halt), .BranchReq(branchReq), .BranchCond(branchCond),
    .BranchIdx(branchIdx), .LutAddr(lutAddr), .LutTarget(lutTarget),
    .ProgCtr(progCtr), .Running(running), .Done(done),
    .BranchTaken(branchTaken), .CycleCnt(cycleCnt)
  );

  pc_sequencer #(.CNT_W(4)) dutSat (
    .Clk(clock), .Reset(reset4), .Start(start4), .StartAddr(8'd0),
    .Stall(1'b0), .Halt(1'b0), .BranchReq(1'b0), .BranchCond(1'b0),
    .BranchIdx(4'd0), .LutAddr(lutAddr4), .LutTarget(8'd0),
    .ProgCtr(progCtr4), .Running(running4), .Done(done4),
    .BranchTaken(branchTaken4), .CycleCnt(cycleCnt4)
  );

  typedef struct {
    logic       start;
    logic [7:0] startAddr;
    logic       stall, halt, breq, bcond;
    logic [3:0] idx;
    logic [7:0] target;
    logic [7:0] expPc;
    logic       expRun, expDone, expTaken;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs[17];

  // Compares one value against its expectation and records the outcome.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs half a period before the rising edge.
  task automatic applyStimulus(input logic st, input logic [7:0] sa, input logic stl,
                               input logic h, input logic br, input logic bc,
                               input logic [3:0] idx, input logic [7:0] tgt);
    @(negedge clock);
    start = st; startAddr = sa; stall = stl; halt = h;
    branchReq = br; branchCond = bc; branchIdx = idx; lutTarget = tgt;
  endtask

  function automatic vec_t mk(input logic st, input logic [7:0] sa, input logic stl,
                              input logic h, input logic br, input logic bc,
                              input logic [3:0] idx, input logic [7:0] tgt,
                              input logic [7:0] pc, input logic r, input logic d,
                              input logic t, input logic [15:0] c);
    vec_t v;
    v.start = st; v.startAddr = sa; v.stall = stl; v.halt = h; v.breq = br;
    v.bcond = bc; v.idx = idx; v.target = tgt; v.expPc = pc; v.expRun = r;
    v.expDone = d; v.expTaken = t; v.expCnt = c;
    return v;
  endfunction

  task automatic checkState(input string tag, input int pc, input int r, input int d,
                            input int t, input int c);
    checkOutput({tag, ".pc"}, progCtr, pc);
    checkOutput({tag, ".running"}, running, r);
    checkOutput({tag, ".done"}, done, d);
    checkOutput({tag, ".taken"}, branchTaken, t);
    checkOutput({tag, ".cnt"}, cycleCnt, c);
  endtask

  initial begin
    //                st  addr stl h  br bc idx tgt    pc   r  d  t  cnt
    vecs[0]  = mk(1, 8'd4,  0, 0, 0, 0, 0, 8'd0,   8'd4,   1, 0, 0, 0);
    vecs[1]  = mk(0, 8'd0,  0, 0, 0, 0, 0, 8'd0,   8'd5,   1, 0, 0, 1);
    vecs[2]  = mk(0, 8'd0,  0, 0, 0, 0, 0, 8'd0,   8'd6,   1, 0, 0, 2);
    vecs[3]  = mk(0, 8'd0,  0, 0, 0, 0, 0, 8'd0,   8'd7,   1, 0, 0, 3);
    vecs[4]  = mk(0, 8'd0,  0, 0, 1, 1, 2, 8'd228, 8'd228, 1, 0, 1, 4);
    vecs[5]  = mk(0, 8'd0,  0, 0, 0, 0, 0, 8'd0,   8'd229, 1, 0, 0, 5);
    vecs[6]  = mk(0, 8'd0,  0, 0, 1, 0, 2, 8'd228, 8'd230, 1, 0, 0, 6);
    vecs[7]  = mk(0, 8'd0,  0, 0, 1, 1, 7, 8'd255, 8'd255, 1, 0, 1, 7);
    vecs[8]  = mk(0, 8'd0,  0, 0, 0, 0, 0, 8'd0,   8'd0,   1, 0, 0, 8);
    vecs[9]  = mk(0, 8'd0,  1, 0, 1, 1, 3, 8'd100, 8'd0,   1, 0, 0, 9);
    vecs[10] = mk(0, 8'd0,  1, 0, 1, 1, 3, 8'd100, 8'd0,   1, 0, 0, 10);
    vecs[11] = mk(0, 8'd0,  0, 0, 1, 1, 5, 8'd50,  8'd50,  1, 0, 1, 11);
    vecs[12] = mk(0, 8'd0,  0, 1, 1, 1, 9, 8'd9,   8'd50,  0, 1, 0, 12);
    vecs[13] = mk(0, 8'd0,  1, 1, 0, 0, 0, 8'd0,   8'd50,  0, 1, 0, 12);
    vecs[14] = mk(1, 8'd0,  0, 0, 0, 0, 0, 8'd0,   8'd0,   1, 0, 0, 0);
    vecs[15] = mk(1, 8'd77, 0, 0, 0, 0, 0, 8'd0,   8'd1,   1, 0, 0, 1);
    vecs[16] = mk(0, 8'd0,  1, 1, 0, 0, 0, 8'd0,   8'd1,   0, 1, 0, 2);

    reset = 1'b1; reset4 = 1'b1; start4 = 1'b0;
    start = 0; startAddr = 0; stall = 0; halt = 0;
    branchReq = 0; branchCond = 0; branchIdx = 0; lutTarget = 0;
    repeat (2) @(posedge clock);
    #1;
    checkState("reset", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].start, vecs[i].startAddr, vecs[i].stall, vecs[i].halt,
                    vecs[i].breq, vecs[i].bcond, vecs[i].idx, vecs[i].target);
      #1;
      checkOutput($sformatf("v%0d.lutaddr", i), lutAddr, vecs[i].idx);
      @(posedge clock);
      #1;
      checkState($sformatf("v%0d", i), vecs[i].expPc, vecs[i].expRun,
                 vecs[i].expDone, vecs[i].expTaken, vecs[i].expCnt);
    end

    // Reset one cycle after a taken-branch edge wipes the pending pulse and PC.
    applyStimulus(1, 8'd10, 0, 0, 0, 0, 0, 8'd0);
    @(posedge clock);
    applyStimulus(0, 8'd0, 0, 0, 1, 1, 4, 8'd200);
    @(posedge clock); #1;
    checkOutput("brk.pc", progCtr, 200);
    checkOutput("brk.taken", branchTaken, 1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checkState("rstBranch", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    // Halt, branch and stall must all be ignored while idle.
    applyStimulus(0, 8'd0, 1, 1, 1, 1, 6, 8'd33);
    @(posedge clock); #1;
    checkState("idleMask", 0, 0, 0, 0, 0);
    applyStimulus(0, 8'd0, 0, 0, 0, 0, 0, 8'd0);

    // Narrow counter build: counts up to 15 and then sticks.
    @(negedge clock);
    reset4 = 1'b0; start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    checkOutput("sat.cnt14", cycleCnt4, 14);
    @(posedge clock); #1;
    checkOutput("sat.cnt15", cycleCnt4, 15);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("sat.hold", cycleCnt4, 15);
    checkOutput("sat.pc", progCtr4, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
